// File: rtl/starfield_layers_if.sv
// Bus between the video pipeline and the starfield generator: pixel enable,
// vertical blank, register write port and the prioritised star pixel.
interface starfield_layers_if;
    logic       en;
    logic       vblank;
    logic [3:0] addr;
    logic [7:0] data_in;
    logic       write;
    logic       sf_on;
    logic [7:0] sf_star;
    logic [2:0] sf_layer;

    modport master (
        output en, vblank, addr, data_in, write,
        input  sf_on, sf_star, sf_layer
    );

    modport slave (
        input  en, vblank, addr, data_in, write,
        output sf_on, sf_star, sf_layer
    );
endinterface

// File: rtl/starfield_layers.sv
// Multi-layer parallax starfield: LAYERS LFSR star planes, each with its own
// scroll speed, fractional accumulator and seed; the front-most enabled star wins.
module starfield_layers #(
    parameter int              H      = 800,
    parameter int              V      = 525,
    parameter int              LAYERS = 3,
    parameter int              LEN    = 25,
    parameter logic [LEN-1:0]  TAPS   = 25'b1010000000000000000000000,
    parameter logic [LEN-1:0]  SEED   = 25'b1111111111111110000000000,
    parameter logic [LEN-1:0]  MASK   = 25'h0001FFF
) (
    input  logic              clk,
    input  logic              rst_n,
    starfield_layers_if.slave bus
);
    localparam logic [LEN-1:0] PERIOD_RST = LEN'(H * V - 1);

    logic [LAYERS-1:0]   enable_reg;
    logic                reseed_reg;
    logic                freeze_reg;
    logic                vblank_last;
    logic                reseed_pulse;
    logic [LAYERS-1:0]   hit;
    logic [8*LAYERS-1:0] star_flat;
    logic                on_next;
    logic [7:0]          star_next;
    logic [2:0]          layer_next;
    logic                on_reg;
    logic [7:0]          star_reg;
    logic [2:0]          layer_reg;

    assign reseed_pulse = bus.en && reseed_reg && bus.vblank && !vblank_last;

    genvar gi;
    generate
        for (gi = 0; gi < LAYERS; gi++) begin : g_layer
            logic [7:0]     speed_reg;
            logic [LEN-1:0] cnt_reg;
            logic [LEN-1:0] period_reg;
            logic [2:0]     acc_reg;
            logic [LEN-1:0] seed_reg;
            logic [LEN-1:0] sreg_reg;
            logic [3:0]     acc_sum;
            logic [5:0]     inc;
            logic           feedback;

            // Carry out of the eighths accumulator adds one extra line of scroll.
            assign acc_sum  = {1'b0, acc_reg} + {1'b0, speed_reg[2:0]};
            assign inc      = freeze_reg ? 6'd0 : ({1'b0, speed_reg[7:3]} + {5'd0, acc_sum[3]});
            assign feedback = ^(sreg_reg & TAPS);

            assign hit[gi] = enable_reg[gi] & (&(sreg_reg | MASK));
            assign star_flat[gi*8 +: 8] = sreg_reg[7:0] >> gi;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    speed_reg  <= 8'd0;
                    cnt_reg    <= '0;
                    period_reg <= PERIOD_RST;
                    acc_reg    <= 3'd0;
                    seed_reg   <= SEED + LEN'(gi);
                    sreg_reg   <= SEED + LEN'(gi);
                end else begin
                    if (bus.write && bus.addr == 4'(gi)) begin
                        speed_reg <= bus.data_in;
                    end
                    if (bus.en) begin
                        sreg_reg <= (cnt_reg == '0) ? seed_reg : {sreg_reg[LEN-2:0], feedback};
                        if (reseed_pulse) begin
                            seed_reg <= seed_reg + LEN'(1);
                        end
                        if (cnt_reg == period_reg) begin
                            cnt_reg    <= '0;
                            period_reg <= LEN'(H * V + int'(inc) * H - 1);
                            if (!freeze_reg) begin
                                acc_reg <= acc_sum[2:0];
                            end
                        end else begin
                            cnt_reg <= cnt_reg + LEN'(1);
                        end
                    end
                end
            end
        end
    endgenerate

    // Walk from the back layer forward so the lowest qualifying index wins.
    always_comb begin
        on_next    = 1'b0;
        star_next  = 8'd0;
        layer_next = 3'd0;
        for (int l = LAYERS - 1; l >= 0; l--) begin
            if (hit[l]) begin
                on_next    = 1'b1;
                star_next  = star_flat[l*8 +: 8];
                layer_next = 3'(l);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enable_reg  <= '1;
            reseed_reg  <= 1'b0;
            freeze_reg  <= 1'b0;
            vblank_last <= 1'b0;
            on_reg      <= 1'b0;
            star_reg    <= 8'd0;
            layer_reg   <= 3'd0;
        end else begin
            if (bus.write && bus.addr == 4'd15) begin
                enable_reg <= bus.data_in[LAYERS-1:0];
                reseed_reg <= bus.data_in[6];
                freeze_reg <= bus.data_in[7];
            end
            if (bus.en) begin
                vblank_last <= bus.vblank;
                on_reg      <= on_next;
                star_reg    <= star_next;
                layer_reg   <= layer_next;
            end
        end
    end

    assign bus.sf_on    = on_reg;
    assign bus.sf_star  = star_reg;
    assign bus.sf_layer = layer_reg;
endmodule

// File: tb/tb_starfield_layers.sv
// Directed bench for starfield_layers with H=8, V=4, two layers and a
// full-density mask so the selected layer's LFSR byte is always visible.
`timescale 1ns/1ps
module tb_starfield_layers;
    localparam int          L    = 2;
    localparam logic [24:0] SEED = 25'b1111111111111110000000000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    starfield_layers_if bus();

    starfield_layers #(
        .H(8), .V(4), .LAYERS(L), .LEN(25),
        .TAPS(25'b1010000000000000000000000),
        .SEED(SEED),
        .MASK(25'h1FFFFFF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int compared   = 0;
    int mismatched = 0;
    string phase = "init";

    // Bench view of each layer: position in frame, hand-given frame lengths.
    int          pos[L];
    int          last_pos[L];
    int          flen[L];
    int          base_len[L];
    logic [24:0] frame_seed[L];
    logic [24:0] seed_now[L];
    int          q0[$];
    int          q1[$];
    logic [7:0]  ctrl_m;
    logic        vb_last;
    logic        exp_on;
    logic [7:0]  exp_star;
    logic [2:0]  exp_layer;

    function automatic logic [24:0] lfsr_at(input logic [24:0] s, input int n);
        logic [24:0] v;
        v = s;
        for (int i = 0; i < n; i++) v = {v[23:0], v[24] ^ v[22]};
        return v;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, expv);
        end
    endtask

    task automatic check_out();
        chk("sf_on", {7'd0, bus.sf_on}, {7'd0, exp_on});
        chk("sf_star", bus.sf_star, exp_star);
        chk("sf_layer", {5'd0, bus.sf_layer}, {5'd0, exp_layer});
    endtask

    task automatic model_reset();
        for (int l = 0; l < L; l++) begin
            pos[l] = 0; last_pos[l] = 0; flen[l] = 32; base_len[l] = 32;
            seed_now[l] = SEED + 25'(l); frame_seed[l] = SEED + 25'(l);
        end
        q0.delete(); q1.delete();
        ctrl_m = 8'h03; vb_last = 1'b0;
        exp_on = 1'b0; exp_star = 8'd0; exp_layer = 3'd0;
    endtask

    task automatic take_len(input int l);
        if (l == 0 && q0.size() > 0)      flen[0] = q0.pop_front();
        else if (l == 1 && q1.size() > 0) flen[1] = q1.pop_front();
        else                              flen[l] = base_len[l];
    endtask

    task automatic tick(input logic vb, input logic wr, input logic [3:0] a, input logic [7:0] d);
        logic [24:0] v;
        exp_on = 1'b0; exp_star = 8'd0; exp_layer = 3'd0;
        for (int l = L - 1; l >= 0; l--) begin
            if (ctrl_m[l]) begin
                v = lfsr_at(frame_seed[l], last_pos[l]);
                exp_on = 1'b1; exp_star = v[7:0] >> l; exp_layer = 3'(l);
            end
        end
        bus.en = 1'b1; bus.vblank = vb; bus.write = wr; bus.addr = a; bus.data_in = d;
        @(posedge clk); #1;
        bus.en = 1'b0; bus.write = 1'b0;
        check_out();
        for (int l = 0; l < L; l++) begin
            if (pos[l] == 0) frame_seed[l] = seed_now[l];
            last_pos[l] = pos[l];
            if (pos[l] == flen[l] - 1) begin
                pos[l] = 0;
                take_len(l);
            end else begin
                pos[l]++;
            end
            if (ctrl_m[6] && vb && !vb_last) seed_now[l] = seed_now[l] + 25'd1;
        end
        vb_last = vb;
        if (wr && a == 4'd15) ctrl_m = d;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 4'd0, 8'd0);
    endtask

    task automatic run_to(input int l, input int p);
        for (int i = 0; i < 200 && pos[l] != p; i++) tick(1'b0, 1'b0, 4'd0, 8'd0);
    endtask

    // Register write on an idle pixel: outputs must hold their last value.
    task automatic wr_idle(input logic [3:0] a, input logic [7:0] d);
        bus.en = 1'b0; bus.write = 1'b1; bus.addr = a; bus.data_in = d;
        @(posedge clk); #1;
        bus.write = 1'b0;
        check_out();
        if (a == 4'd15) ctrl_m = d;
    endtask

    task automatic do_reset(input logic wr);
        rst_n = 1'b0; bus.en = 1'b0; bus.write = wr; bus.addr = 4'd0; bus.data_in = 8'h10;
        @(posedge clk); #1;
        rst_n = 1'b1; bus.write = 1'b0;
        model_reset();
        check_out();
    endtask

    task automatic report();
        $display("step %s: compared %0d, mismatched %0d", phase, compared, mismatched);
    endtask

    initial begin
        bus.en = 1'b0; bus.vblank = 1'b0; bus.write = 1'b0; bus.addr = 4'd0; bus.data_in = 8'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        phase = "reset_defaults";
        do_reset(1'b0);
        step(96);
        report();

        phase = "speed_write_midframe";
        run_to(0, 10);
        wr_idle(4'd0, 8'h10);
        base_len[0] = 48;
        run_to(0, 0);
        step(96);
        wr_idle(4'd15, 8'h02);
        step(64);
        wr_idle(4'd15, 8'h03);
        report();

        phase = "write_collision";
        run_to(0, 47);
        q0.push_back(48);
        base_len[0] = 32;
        tick(1'b0, 1'b1, 4'd0, 8'h00);
        step(88);
        report();

        phase = "fractional_speed";
        wr_idle(4'd15, 8'h02);
        wr_idle(4'd1, 8'h03);
        q1 = '{32, 32, 40, 32, 32, 40, 32, 40};
        for (int i = 0; i < 400 && q1.size() > 0; i++) tick(1'b0, 1'b0, 4'd0, 8'd0);
        step(5);
        wr_idle(4'd1, 8'h00);
        step(80);
        report();

        phase = "layer_select";
        wr_idle(4'd15, 8'h03);
        step(20);
        wr_idle(4'd15, 8'h00);
        step(10);
        wr_idle(4'd15, 8'h01);
        step(5);
        wr_idle(4'd15, 8'h03);
        report();

        phase = "reseed";
        wr_idle(4'd15, 8'h43);
        tick(1'b1, 1'b0, 4'd0, 8'd0);
        tick(1'b0, 1'b0, 4'd0, 8'd0);
        tick(1'b1, 1'b0, 4'd0, 8'd0);
        tick(1'b0, 1'b0, 4'd0, 8'd0);
        step(80);
        wr_idle(4'd15, 8'h03);
        tick(1'b1, 1'b0, 4'd0, 8'd0);
        tick(1'b0, 1'b0, 4'd0, 8'd0);
        step(80);
        report();

        phase = "freeze";
        wr_idle(4'd15, 8'h83);
        wr_idle(4'd0, 8'hFF);
        wr_idle(4'd1, 8'hFF);
        step(100);
        wr_idle(4'd0, 8'h00);
        wr_idle(4'd1, 8'h00);
        step(50);
        wr_idle(4'd15, 8'h03);
        step(70);
        report();

        phase = "reset_midframe";
        step(10);
        do_reset(1'b1);
        step(70);
        report();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
